// File: rtl/order_egress_arbiter_if.sv
// Order path bundle: requester handshakes and fields, encoder strobe, encoder stream monitor.
interface order_egress_arbiter_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    req_buy;
  logic [32*N_REQ-1:0] req_px;
  logic [32*N_REQ-1:0] req_qty;
  logic                enc_in_valid;
  logic                enc_in_buy;
  logic [31:0]         enc_in_px;
  logic [31:0]         enc_in_qty;
  logic                enc_tvalid;
  logic                enc_tready;
  logic                enc_tlast;

  modport master (
    output req_valid, req_buy, req_px, req_qty, enc_tvalid, enc_tready, enc_tlast,
    input  req_ready, enc_in_valid, enc_in_buy, enc_in_px, enc_in_qty
  );

  modport slave (
    input  req_valid, req_buy, req_px, req_qty, enc_tvalid, enc_tready, enc_tlast,
    output req_ready, enc_in_valid, enc_in_buy, enc_in_px, enc_in_qty
  );
endinterface

// File: rtl/order_egress_arbiter.sv
// Round-robin arbiter feeding one order encoder, rate limited by a token bucket.
// state      | meaning
// IDLE       | waiting for an eligible requester (kill low, tokens > 0)
// ISSUE      | one-cycle strobe of the latched order into the encoder
// WAIT_FRAME | waiting for the encoder frame's final beat handshake
module order_egress_arbiter #(
  parameter int N_REQ         = 4,
  parameter int TOKENS_MAX    = 8,
  parameter int REFILL_CYCLES = 100,
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int TW = $clog2(TOKENS_MAX + 1),
  localparam int RW = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         kill,
  order_egress_arbiter_if.slave        bus,
  output logic [GW-1:0]                grant_id,
  output logic [TW-1:0]                tokens,
  output logic                         busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_FRAME} state_t;

  state_t        state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] winner;
  logic [RW-1:0] refill_cnt;
  logic          found;
  logic          eligible;
  logic          accept;
  logic          refill_tc;
  logic          consume;

  // Search starts just after the previous winner so every requester gets a turn.
  always_comb begin
    int            idx;
    logic [GW-1:0] idx_w;
    winner = last_grant;
    found  = 1'b0;
    idx    = 0;
    idx_w  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_w = GW'(idx);
      if (!found && bus.req_valid[idx_w]) begin
        winner = idx_w;
        found  = 1'b1;
      end
    end
  end

  assign eligible = (state == IDLE) && !kill && (tokens != '0) && found;

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < N_REQ; i++)
      bus.req_ready[i] = eligible && (winner == GW'(i));
  end

  assign accept    = |(bus.req_valid & bus.req_ready);
  assign refill_tc = (refill_cnt == RW'(REFILL_CYCLES - 1));
  assign consume   = (state == ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      last_grant       <= GW'(N_REQ - 1);
      grant_id         <= '0;
      bus.enc_in_valid <= 1'b0;
      bus.enc_in_buy   <= 1'b0;
      bus.enc_in_px    <= '0;
      bus.enc_in_qty   <= '0;
      busy             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus.enc_in_buy   <= bus.req_buy[winner];
            bus.enc_in_px    <= bus.req_px[{winner, 5'd0} +: 32];
            bus.enc_in_qty   <= bus.req_qty[{winner, 5'd0} +: 32];
            grant_id         <= winner;
            last_grant       <= winner;
            bus.enc_in_valid <= 1'b1;
            busy             <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          bus.enc_in_valid <= 1'b0;
          state            <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (bus.enc_tvalid && bus.enc_tready && bus.enc_tlast) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          bus.enc_in_valid <= 1'b0;
          busy             <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end

  // A refill landing on the consuming edge cancels out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refill_cnt <= '0;
      tokens     <= TW'(TOKENS_MAX);
    end else begin
      refill_cnt <= refill_tc ? '0 : refill_cnt + 1'b1;
      if (refill_tc && !consume && (tokens < TW'(TOKENS_MAX)))
        tokens <= tokens + 1'b1;
      else if (consume && !refill_tc)
        tokens <= tokens - 1'b1;
    end
  end

endmodule

// File: tb/tb_order_egress_arbiter.sv
// Randomized and directed bench for order_egress_arbiter against a cycle-level reference model.
module tb_order_egress_arbiter;
  localparam int N      = 4;
  localparam int TMAX   = 8;
  localparam int REFILL = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       kill = 1'b0;
  logic [1:0] grant_id;
  logic [3:0] tokens;
  logic       busy;

  order_egress_arbiter_if #(.N_REQ(N)) bus();

  order_egress_arbiter #(.N_REQ(N), .TOKENS_MAX(TMAX), .REFILL_CYCLES(REFILL)) dut (
    .clk(clk), .rst_n(rst_n), .kill(kill), .bus(bus),
    .grant_id(grant_id), .tokens(tokens), .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail = 0;
  int          m_tok, m_cnt, m_phase, m_last, m_grant, m_beat;
  logic        m_buy;
  logic [31:0] m_px, m_qty;
  int          cyc;
  bit          enc_random = 1'b0;
  bit          enc_rdy = 1'b1;
  int          frame_len = 2;
  int          issue_cycles[$];
  int          issue_ids[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tok = TMAX; m_cnt = 0; m_phase = 0; m_last = N - 1; m_grant = 0; m_beat = 0;
    m_buy = 1'b0; m_px = '0; m_qty = '0;
    cyc = 0;
    issue_cycles.delete();
    issue_ids.delete();
  endtask

  // One clock: drive encoder, check at negedge, advance the model across the rising edge.
  task automatic step();
    int         w;
    int         ntok;
    logic [3:0] er;
    logic [3:0] v;
    logic [6:0] off;
    bit         refill, consume, hs;
    if (enc_random) begin
      bus.enc_tvalid = 1'($urandom_range(0, 1));
      bus.enc_tready = 1'($urandom_range(0, 1));
      bus.enc_tlast  = 1'($urandom_range(0, 1));
    end else begin
      bus.enc_tvalid = (m_phase == 2);
      bus.enc_tready = enc_rdy;
      bus.enc_tlast  = (m_beat == frame_len - 1);
    end
    @(negedge clk);
    w = -1;
    v = bus.req_valid;
    if (m_phase == 0 && !kill && m_tok > 0)
      for (int k = 1; k <= N; k++) begin
        int c = (m_last + k) % N;
        if (w < 0 && v[2'(c)]) w = c;
      end
    er = (w >= 0) ? (4'd1 << w) : 4'd0;
    check("req_ready", 32'(bus.req_ready), 32'(er));
    check("enc_in_valid", 32'(bus.enc_in_valid), 32'(m_phase == 1));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("tokens", 32'(tokens), m_tok);
    check("grant_id", 32'(grant_id), m_grant);
    check("enc_in_buy", 32'(bus.enc_in_buy), 32'(m_buy));
    check("enc_in_px", bus.enc_in_px, m_px);
    check("enc_in_qty", bus.enc_in_qty, m_qty);
    if (bus.enc_in_valid) begin
      issue_cycles.push_back(cyc);
      issue_ids.push_back(int'(grant_id));
    end
    refill  = (m_cnt == REFILL - 1);
    consume = (m_phase == 1);
    ntok = m_tok;
    if (refill && !consume && m_tok < TMAX) ntok = m_tok + 1;
    else if (consume && !refill) ntok = m_tok - 1;
    hs = bus.enc_tvalid && bus.enc_tready;
    @(posedge clk);
    m_tok = ntok;
    m_cnt = (m_cnt + 1) % REFILL;
    case (m_phase)
      0: if (w >= 0) begin
        off = {2'(w), 5'd0};
        m_buy = bus.req_buy[2'(w)];
        m_px  = bus.req_px[off +: 32];
        m_qty = bus.req_qty[off +: 32];
        m_last = w; m_grant = w; m_phase = 1;
      end
      1: m_phase = 2;
      default: if (hs) begin
        if (bus.enc_tlast) begin m_phase = 0; m_beat = 0; end
        else m_beat = m_beat + 1;
      end
    endcase
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_wait_frame();
    int budget = 30;
    while (m_phase != 2 && budget > 0) begin step(); budget--; end
    check("reach_wait_frame", 32'(m_phase), 32'd2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    kill  = 1'b0;
    #2;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      bus.req_px[i*32 +: 32]  = $urandom;
      bus.req_qty[i*32 +: 32] = $urandom;
    end
    bus.req_buy = 4'($urandom_range(0, 15));
  endtask

  initial begin
    int n0;
    bus.req_valid = '0; bus.req_buy = '0; bus.req_px = '0; bus.req_qty = '0;
    bus.enc_tvalid = 1'b0; bus.enc_tready = 1'b0; bus.enc_tlast = 1'b0;
    #12;
    check("rst_tokens", 32'(tokens), TMAX);
    check("rst_busy", 32'(busy), 0);
    check("rst_enc_valid", 32'(bus.enc_in_valid), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_px", bus.enc_in_px, 0);
    check("rst_qty", bus.enc_in_qty, 0);
    model_reset();
    @(posedge clk); #1; rst_n = 1'b1;

    // Single request on requester 2
    bus.req_valid = 4'b0100; bus.req_buy = 4'b0100;
    bus.req_px[64 +: 32] = 32'd10050; bus.req_qty[64 +: 32] = 32'd500;
    step();
    bus.req_valid = '0;
    run(5);
    check("single_count", issue_ids.size(), 1);
    if (issue_ids.size() > 0) begin
      check("single_id", issue_ids[0], 2);
      check("single_latency", issue_cycles[0], 1);
    end
    check("single_px", bus.enc_in_px, 10050);
    check("single_qty", bus.enc_in_qty, 500);
    check("single_tokens", 32'(tokens), 7);

    // Round robin with 2-beat frames
    do_reset();
    frame_len = 2; rand_fields(); bus.req_valid = 4'hf;
    run(20);
    check("rr_count", issue_ids.size(), 5);
    for (int i = 0; i < 5 && i < issue_ids.size(); i++) begin
      check("rr_order", issue_ids[i], (i % 4));
      if (i > 0) check("rr_spacing", issue_cycles[i] - issue_cycles[i-1], 4);
    end

    // Rate limit: 8 tokens drain, 9th only after refill terminal count
    do_reset();
    frame_len = 1; bus.req_valid = 4'hf;
    run(60);
    check("rate_count8", issue_ids.size(), 8);
    check("rate_tokens0", 32'(tokens), 0);
    while (issue_ids.size() < 9 && cyc < 150) step();
    check("rate_count9", issue_ids.size(), 9);
    if (issue_cycles.size() > 8) check("rate_ninth_cycle", issue_cycles[8], REFILL + 1);

    // Backpressure in WAIT_FRAME
    do_reset();
    frame_len = 2; enc_rdy = 1'b0; bus.req_valid = 4'b0010;
    wait_wait_frame();
    run(20);
    check("bp_busy", 32'(busy), 1);
    check("bp_ready", 32'(bus.req_ready), 0);
    enc_rdy = 1'b1;
    run(6);
    check("bp_resumed", issue_ids.size(), 2);

    // Kill during WAIT_FRAME
    bus.req_valid = 4'hf;
    wait_wait_frame();
    kill = 1'b1;
    run(10);
    check("kill_frame_done", 32'(busy), 0);
    n0 = issue_ids.size();
    run(10);
    check("kill_no_grant", issue_ids.size(), n0);
    kill = 1'b0;
    run(4);
    check("kill_release", issue_ids.size(), n0 + 1);

    // Async reset during WAIT_FRAME
    wait_wait_frame();
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_enc_valid", 32'(bus.enc_in_valid), 0);
    check("arst_tokens", 32'(tokens), TMAX);
    check("arst_grant", 32'(grant_id), 0);
    check("arst_px", bus.enc_in_px, 0);
    do_reset();
    bus.req_valid = 4'hf;
    run(4);
    check("arst_count", issue_ids.size(), 1);
    if (issue_ids.size() > 0) check("arst_first_id", issue_ids[0], 0);

    // Random traffic
    enc_random = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      bus.req_valid = 4'($urandom_range(0, 15));
      rand_fields();
      kill = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
